i2s_tx: RTL and testbench

Final stage of the effect chain. Consumes the processed mono sample stream (signed DATA_WIDTH, one-cycle valid strobes) from the last effect stage and serialises it as standard Philips I2S to the external audio DAC. The same sample is sent on both the left and right channels. SCLK and LRCK are generated from clk. MCLK is supplied externally.

---
 rtl/i2s_tx.sv | 141 ++++++++++++++
 tb/tb_i2s_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: serialises a mono sample stream as Philips I2S.
// The same word goes to both channels. SCLK and LRCK are divided down from clk.
// A sample accepted before a frame wrap appears on sd_o from the next frame.
// No backpressure: samples are absorbed into a one-deep holding register.
// Overrun and underrun are reported as one-cycle pulses.
module i2s_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int SLOT_WIDTH = 24,
   parameter int SCLK_HALF  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   input  logic                         vld_i,
   output logic                         sclk_o,
   output logic                         lrck_o,
   output logic                         sd_o,
   output logic                         frame_o,
   output logic                         underrun_o,
   output logic                         overrun_o
);

   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int PW         = $clog2(FRAME_BITS);
   localparam int DVW        = $clog2(SCLK_HALF);
   localparam int IW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   // clock divider and bit clock
   logic [DVW-1:0]        r_div;
   logic                  r_sclk;

   // frame position and serial outputs
   logic [PW-1:0]         r_p;
   logic                  r_lrck;
   logic                  r_sd;

   // sample path
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  r_pending;
   logic [DATA_WIDTH-1:0] r_frame;
   logic                  r_frame_pls;
   logic                  r_underrun;
   logic                  r_overrun;

   logic                  w_div_tc;
   logic                  w_fall;
   logic                  w_p_last;
   logic                  w_load;
   logic [PW-1:0]         w_p_nxt;
   logic [PW-1:0]         w_slot_pos;
   logic                  w_in_data;
   logic [IW-1:0]         w_idx;
   logic                  w_bit;
   logic                  w_lrck_nxt;

   // The divider wraps every SCLK_HALF cycles. A falling tick is a wrap
   // while sclk is high, which is when the DAC-facing data may change.
   assign w_div_tc = (r_div == DVW'(SCLK_HALF - 1));
   assign w_fall   = w_div_tc & r_sclk;

   // Bit position wraps after 2*SLOT_WIDTH bits. The frame register is
   // reloaded only on the wrap tick, so it stays stable for a whole frame.
   assign w_p_last = (r_p == PW'(FRAME_BITS - 1));
   assign w_p_nxt  = w_p_last ? '0 : r_p + PW'(1);
   assign w_load   = w_fall & w_p_last;

   // Position within the current channel slot. Slot bit 0 is the one-bit
   // I2S delay. The MSB sits at slot bit 1, and the LSB sits at
   // slot bit DATA_WIDTH.
   assign w_lrck_nxt = (w_p_nxt >= PW'(SLOT_WIDTH));
   assign w_slot_pos = w_lrck_nxt ? (w_p_nxt - PW'(SLOT_WIDTH)) : w_p_nxt;
   assign w_in_data  = (w_slot_pos != '0) && (w_slot_pos <= PW'(DATA_WIDTH));

   // DATA_WIDTH - slot_pos lies within 0..DATA_WIDTH-1 whenever w_in_data
   // is set. Modular arithmetic on the low IW bits is therefore exact.
   assign w_idx = IW'(DATA_WIDTH) - w_slot_pos[IW-1:0];
   assign w_bit = r_frame[w_idx];

   // Divide clk into the bit clock; sclk rises SCLK_HALF cycles after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (w_div_tc) begin
         r_div  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_div  <= r_div + DVW'(1);
      end
   end

   // Advance the bit position on falling ticks and present LRCK/SD for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p    <= '0;
         r_lrck <= 1'b0;
         r_sd   <= 1'b0;
      end else if (w_fall) begin
         r_p    <= w_p_nxt;
         r_lrck <= w_lrck_nxt;
         r_sd   <= w_in_data & w_bit;
      end
   end

   // Hold the newest sample, load it into the frame at the wrap, and flag
   // overrun and underrun. A strobe on the wrap cycle is not an overrun.
   // The frame takes the old hold value, and the new sample stays pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= '0;
         r_pending   <= 1'b0;
         r_frame     <= '0;
         r_frame_pls <= 1'b0;
         r_underrun  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_pls <= w_load;
         r_underrun  <= w_load & ~r_pending;
         r_overrun   <= vld_i & r_pending & ~w_load;
         if (w_load) begin
            r_frame <= r_hold;
         end
         if (vld_i) begin
            r_hold <= data_i;
         end
         if (vld_i) begin
            r_pending <= 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign sclk_o     = r_sclk;
   assign lrck_o     = r_lrck;
   assign sd_o       = r_sd;
   assign frame_o    = r_frame_pls;
   assign underrun_o = r_underrun;
   assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: directed vectors on a default instance and a wide instance.
// Expected bit streams and pulse times are hand-derived constants.
// Cycle numbering restarts at 0 whenever a reset is released.
module tb_i2s_tx;

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   logic [7:0]  data_a;
   logic [15:0] data_b;
   logic        vld_a;
   logic        vld_b;
   logic        sclk_a, lrck_a, sd_a, frame_a, underrun_a, overrun_a;
   logic        sclk_b, lrck_b, sd_b, frame_b, underrun_b, overrun_b;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   i2s_tx u_dut_a (
      .clk        (clk),
      .rst        (rst_a),
      .data_i     (data_a),
      .vld_i      (vld_a),
      .sclk_o     (sclk_a),
      .lrck_o     (lrck_a),
      .sd_o       (sd_a),
      .frame_o    (frame_a),
      .underrun_o (underrun_a),
      .overrun_o  (overrun_a)
   );

   i2s_tx #(
      .DATA_WIDTH (16),
      .SLOT_WIDTH (32),
      .SCLK_HALF  (2)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst_b),
      .data_i     (data_b),
      .vld_i      (vld_b),
      .sclk_o     (sclk_b),
      .lrck_o     (lrck_b),
      .sd_o       (sd_b),
      .frame_o    (frame_b),
      .underrun_o (underrun_b),
      .overrun_o  (overrun_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic pulse_a(input int c, input logic [7:0] d);
      goto(c - 1);
      data_a = d;
      vld_a  = 1'b1;
      tick();
      vld_a  = 1'b0;
   endtask

   task automatic pulse_b(input int c, input logic [15:0] d);
      goto(c - 1);
      data_b = d;
      vld_b  = 1'b1;
      tick();
      vld_b  = 1'b0;
   endtask

   task automatic check_zero_a(input string tag);
      check_eq({tag, "_sclk"}, sclk_a, 0);
      check_eq({tag, "_lrck"}, lrck_a, 0);
      check_eq({tag, "_sd"}, sd_a, 0);
      check_eq({tag, "_frame"}, frame_a, 0);
      check_eq({tag, "_underrun"}, underrun_a, 0);
      check_eq({tag, "_overrun"}, overrun_a, 0);
   endtask

   // Default instance: bit p of a frame starting at base is held from
   // base+8p. It is sampled at the SCLK rise, at base+8p+4.
   task automatic check_frame_a(input int base, input logic [7:0] d, input int pmax);
      for (int p = 0; p <= pmax; p++) begin
         int   s;
         logic exp;
         goto(base + 8 * p + 4);
         s   = p % 24;
         exp = (s >= 1 && s <= 8) ? d[8 - s] : 1'b0;
         check_eq($sformatf("a_sd_f%0d_p%0d", base, p), sd_a, exp);
         check_eq($sformatf("a_lrck_f%0d_p%0d", base, p), lrck_a, (p >= 24) ? 1 : 0);
      end
   endtask

   initial begin
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      vld_a  = 1'b0;
      vld_b  = 1'b0;
      data_a = '0;
      data_b = '0;

      // ---------------- power-up reset, default instance
      repeat (3) tick();
      check_zero_a("a_rst");
      rst_a = 1'b0;
      cyc   = 0;
      goto(3);
      check_eq("a_sclk_c3", sclk_a, 0);
      goto(4);
      check_eq("a_sclk_rise_c4", sclk_a, 1);
      goto(7);
      check_eq("a_sclk_c7", sclk_a, 1);
      goto(8);
      check_eq("a_sclk_fall_c8", sclk_a, 0);
      check_eq("a_lrck_c8", lrck_a, 0);

      // ---------------- single sample A5 in frame 0
      pulse_a(100, 8'hA5);
      check_eq("a_ovr_first", overrun_a, 0);
      goto(383);
      check_eq("a_frame_pre_wrap1", frame_a, 0);
      goto(384);
      check_eq("a_frame_wrap1", frame_a, 1);
      check_eq("a_udr_wrap1", underrun_a, 0);
      check_eq("a_ovr_wrap1", overrun_a, 0);
      tick();
      check_eq("a_frame_post_wrap1", frame_a, 0);
      check_frame_a(384, 8'hA5, 47);

      // ---------------- underrun: nothing sent, A5 repeats
      goto(768);
      check_eq("a_frame_wrap2", frame_a, 1);
      check_eq("a_udr_wrap2", underrun_a, 1);
      tick();
      check_eq("a_udr_post_wrap2", underrun_a, 0);
      check_frame_a(768, 8'hA5, 47);

      // ---------------- overrun: 12 then 80, newest wins
      pulse_a(1149, 8'h12);
      check_eq("a_ovr_12", overrun_a, 0);
      pulse_a(1150, 8'h80);
      check_eq("a_ovr_80", overrun_a, 1);
      tick();
      check_eq("a_ovr_clear", overrun_a, 0);
      goto(1152);
      check_eq("a_frame_wrap3", frame_a, 1);
      check_eq("a_udr_wrap3", underrun_a, 0);
      check_frame_a(1152, 8'h80, 47);

      // ---------------- collision: C3 pending, 3C strobed on the wrap cycle
      pulse_a(1533, 8'hC3);
      check_eq("a_ovr_c3", overrun_a, 0);
      pulse_a(1536, 8'h3C);
      check_eq("a_frame_wrap4", frame_a, 1);
      check_eq("a_udr_wrap4", underrun_a, 0);
      check_eq("a_ovr_wrap4", overrun_a, 0);
      check_frame_a(1536, 8'hC3, 47);
      goto(1920);
      check_eq("a_frame_wrap5", frame_a, 1);
      check_eq("a_udr_wrap5", underrun_a, 0);
      check_eq("a_ovr_wrap5", overrun_a, 0);

      // ---------------- reset mid-frame while shifting 3C with FF pending
      check_frame_a(1920, 8'h3C, 3);
      check_eq("a_sclk_before_midrst", sclk_a, 1);
      pulse_a(1949, 8'hFF);
      rst_a = 1'b1;
      repeat (3) tick();
      check_zero_a("a_midrst");
      rst_a = 1'b0;
      cyc   = 0;
      goto(3);
      check_eq("a_mr_sclk_c3", sclk_a, 0);
      goto(4);
      check_eq("a_mr_sclk_rise_c4", sclk_a, 1);
      goto(8);
      check_eq("a_mr_sclk_fall_c8", sclk_a, 0);
      check_eq("a_mr_sd_c8", sd_a, 0);
      goto(383);
      check_eq("a_mr_frame_pre_wrap", frame_a, 0);
      goto(384);
      check_eq("a_mr_frame_wrap", frame_a, 1);
      check_eq("a_mr_udr_wrap", underrun_a, 1);
      check_frame_a(384, 8'h00, 47);

      // ---------------- wide instance: DATA 16, SLOT 32, SCLK_HALF 2
      tick();
      rst_b = 1'b0;
      cyc   = 0;
      check_eq("b_rst_sclk", sclk_b, 0);
      check_eq("b_rst_lrck", lrck_b, 0);
      check_eq("b_rst_sd", sd_b, 0);
      check_eq("b_rst_frame", frame_b, 0);
      check_eq("b_rst_udr", underrun_b, 0);
      check_eq("b_rst_ovr", overrun_b, 0);
      goto(1);
      check_eq("b_sclk_c1", sclk_b, 0);
      goto(2);
      check_eq("b_sclk_rise_c2", sclk_b, 1);
      goto(3);
      check_eq("b_sclk_c3", sclk_b, 1);
      goto(4);
      check_eq("b_sclk_fall_c4", sclk_b, 0);
      pulse_b(50, 16'h8001);
      check_eq("b_ovr_first", overrun_b, 0);
      goto(255);
      check_eq("b_frame_pre_wrap1", frame_b, 0);
      goto(256);
      check_eq("b_frame_wrap1", frame_b, 1);
      check_eq("b_udr_wrap1", underrun_b, 0);
      for (int p = 0; p < 64; p++) begin
         int s;
         goto(256 + 4 * p + 2);
         s = p % 32;
         check_eq($sformatf("b_sd_p%0d", p), sd_b, (s == 1 || s == 16) ? 1 : 0);
         check_eq($sformatf("b_lrck_p%0d", p), lrck_b, (p >= 32) ? 1 : 0);
      end
      goto(511);
      check_eq("b_frame_pre_wrap2", frame_b, 0);
      goto(512);
      check_eq("b_frame_wrap2", frame_b, 1);
      check_eq("b_udr_wrap2", underrun_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
